// File: rtl/action_lookup.sv
// action_lookup
//
// Resolves the time-aligned match result from the action delay line into a
// per-packet action word. Hits read the external action memory (1-cycle read
// latency); misses take the fixed table-miss action. Results are queued in an
// order-preserving FIFO and offered downstream with valid/ready. The match
// pipeline upstream cannot be stalled, so entries that would not fit are
// dropped at admission and counted.
//
// Ports
//   clk            single clock, rising edge
//   reset          asynchronous, active-low reset
//   match_valid    one-cycle strobe, match result present
//   match_hit      1 = flow entry hit, 0 = miss
//   match_addr     matched flow-table entry address (ignored on miss)
//   match_in_port  ingress port of the packet
//   act_rd_en      action memory read strobe (combinational from match inputs)
//   act_rd_addr    action memory address
//   act_rd_data    action memory read data, valid 1 cycle after act_rd_en
//   act_valid      result available at FIFO head
//   act_ready      downstream accepts result
//   act_data       action word
//   act_in_port    ingress port carried through
//   act_hit        hit flag carried through
//   drop_count     results dropped on FIFO overflow (saturating)
//   hit_count      admitted hits (saturating, optional)
//   miss_count     admitted misses (saturating, optional)
//
// Build option
//   ACTION_LOOKUP_STATS_EN  when defined, hit_count/miss_count are real
//                           counters; otherwise both are tied to zero.

module action_lookup #(
    parameter int C_IN_PORT_WIDTH    = 8,
    parameter int C_MATCH_ADDR_WIDTH = 10,
    parameter int C_ACTION_WIDTH     = 32,
    parameter int C_FIFO_DEPTH       = 8,
    parameter logic [C_ACTION_WIDTH-1:0] C_MISS_ACTION = 32'h0000_0001
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic                          match_valid,
    input  logic                          match_hit,
    input  logic [C_MATCH_ADDR_WIDTH-1:0] match_addr,
    input  logic [C_IN_PORT_WIDTH-1:0]    match_in_port,

    output logic                          act_rd_en,
    output logic [C_MATCH_ADDR_WIDTH-1:0] act_rd_addr,
    input  logic [C_ACTION_WIDTH-1:0]     act_rd_data,

    output logic                          act_valid,
    input  logic                          act_ready,
    output logic [C_ACTION_WIDTH-1:0]     act_data,
    output logic [C_IN_PORT_WIDTH-1:0]    act_in_port,
    output logic                          act_hit,

    output logic [31:0]                   drop_count,
    output logic [31:0]                   hit_count,
    output logic [31:0]                   miss_count
);

    localparam int AW = $clog2(C_FIFO_DEPTH);
    localparam int EW = C_ACTION_WIDTH + C_IN_PORT_WIDTH + 1;
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(C_FIFO_DEPTH);

    // ------------------------------------------------------------------
    // FIFO pointers and status
    // ------------------------------------------------------------------
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   occupancy;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    assign occupancy  = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // ------------------------------------------------------------------
    // S1: admission
    // ------------------------------------------------------------------
    // The S2 entry already owns a slot, so it is reserved here. A pop in the
    // same cycle is deliberately not credited; this keeps admission off the
    // act_ready path at the cost of occasionally dropping one entry early.
    logic          s2_valid;
    logic          s2_hit;
    logic [C_IN_PORT_WIDTH-1:0] s2_in_port;
    logic [AW+1:0] committed;
    logic          admit;
    logic          reject;

    assign committed = {1'b0, occupancy} + {{(AW+1){1'b0}}, s2_valid};
    assign admit     = match_valid && (committed < DEPTH_W);
    assign reject    = match_valid && !admit;

    always_comb begin
        act_rd_en   = 1'b0;
        act_rd_addr = '0;
        if (admit && match_hit) begin
            act_rd_en   = 1'b1;
            act_rd_addr = match_addr;
        end
    end

    // ------------------------------------------------------------------
    // S2: wait for read data, then push. Misses also take this stage so
    // they stay in order behind earlier hits.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid   <= 1'b0;
            s2_hit     <= 1'b0;
            s2_in_port <= '0;
        end else begin
            s2_valid <= admit;
            if (admit) begin
                s2_hit     <= match_hit;
                s2_in_port <= match_in_port;
            end
        end
    end

    logic [C_ACTION_WIDTH-1:0] s2_action;
    logic [EW-1:0]             push_entry;

    assign s2_action  = s2_hit ? act_rd_data : C_MISS_ACTION;
    assign push_entry = {s2_action, s2_in_port, s2_hit};

    // Admission guarantees space; the full guard only protects the
    // storage should that invariant ever be broken.
    assign push = s2_valid && !fifo_full;
    assign pop  = !fifo_empty && act_ready;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [EW-1:0] fifo_mem [C_FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output: head entry, forced to zero while empty so stale storage never
    // leaks out (storage itself is not reset).
    // ------------------------------------------------------------------
    logic [EW-1:0] head_entry;

    assign head_entry = fifo_mem[rd_ptr[AW-1:0]];

    always_comb begin
        act_valid   = !fifo_empty;
        act_data    = '0;
        act_in_port = '0;
        act_hit     = 1'b0;
        if (!fifo_empty) begin
            act_data    = head_entry[EW-1 -: C_ACTION_WIDTH];
            act_in_port = head_entry[C_IN_PORT_WIDTH:1];
            act_hit     = head_entry[0];
        end
    end

    // ------------------------------------------------------------------
    // Counters, all saturating
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count <= '0;
        end else if (reject && (drop_count != 32'hFFFF_FFFF)) begin
            drop_count <= drop_count + 32'd1;
        end
    end

`ifdef ACTION_LOOKUP_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count <= '0;
        end else if (admit && match_hit && (hit_count != 32'hFFFF_FFFF)) begin
            hit_count <= hit_count + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            miss_count <= '0;
        end else if (admit && !match_hit && (miss_count != 32'hFFFF_FFFF)) begin
            miss_count <= miss_count + 32'd1;
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_action_lookup.sv
module tb_action_lookup;

    logic        clk;
    logic        reset;
    logic        match_valid;
    logic        match_hit;
    logic [9:0]  match_addr;
    logic [7:0]  match_in_port;
    logic        act_rd_en;
    logic [9:0]  act_rd_addr;
    logic [31:0] act_rd_data;
    logic        act_valid;
    logic        act_ready;
    logic [31:0] act_data;
    logic [7:0]  act_in_port;
    logic        act_hit;
    logic [31:0] drop_count;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int errors = 0;
    int checks = 0;

    logic [40:0] outq [$];

    action_lookup dut (
        .clk           (clk),
        .reset         (reset),
        .match_valid   (match_valid),
        .match_hit     (match_hit),
        .match_addr    (match_addr),
        .match_in_port (match_in_port),
        .act_rd_en     (act_rd_en),
        .act_rd_addr   (act_rd_addr),
        .act_rd_data   (act_rd_data),
        .act_valid     (act_valid),
        .act_ready     (act_ready),
        .act_data      (act_data),
        .act_in_port   (act_in_port),
        .act_hit       (act_hit),
        .drop_count    (drop_count),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [9:0] addr);
        if (addr == 10'h005) return 32'hDEAD_BEEF;
        return 32'hA5A5_0000 | {22'd0, addr};
    endfunction

    function automatic logic [40:0] ent(input logic hit, input logic [9:0] addr,
                                        input logic [7:0] port);
        return {(hit ? mem_f(addr) : 32'h0000_0001), port, hit};
    endfunction

    // Action memory model: 1-cycle read latency
    always @(posedge clk) begin
        if (act_rd_en) act_rd_data <= mem_f(act_rd_addr);
    end

    // Record every accepted result at the sampling edge
    always @(negedge clk) begin
        if (reset && act_valid && act_ready)
            outq.push_back({act_data, act_in_port, act_hit});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, return at the
    // following falling edge where outputs are sampled.
    task automatic cyc(input logic v, input logic h, input logic [9:0] a,
                       input logic [7:0] p, input logic rdy);
        @(posedge clk);
        #1;
        match_valid   = v;
        match_hit     = h;
        match_addr    = a;
        match_in_port = p;
        act_ready     = rdy;
        @(negedge clk);
    endtask

    logic [31:0] exp_hits;
    logic [31:0] exp_miss;
    int          qn;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b0;
        match_valid   = 1'b0;
        match_hit     = 1'b0;
        match_addr    = '0;
        match_in_port = '0;
        act_ready     = 1'b0;
        act_rd_data   = '0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(act_valid), 64'd0);
        check("rst_data",  64'(act_data),  64'd0);
        check("rst_rden",  64'(act_rd_en), 64'd0);
        check("rst_drop",  64'(drop_count), 64'd0);
        check("rst_hits",  64'(hit_count),  64'd0);
        check("rst_miss",  64'(miss_count), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // ---------------- single hit ----------------
        cyc(1, 1, 10'h005, 8'h3C, 1);
        check("hit_rden_t",  64'(act_rd_en),   64'd1);
        check("hit_raddr_t", 64'(act_rd_addr), 64'h005);
        check("hit_valid_t", 64'(act_valid),   64'd0);
        cyc(0, 0, 10'h000, 8'h00, 1);
        check("hit_rden_t1",  64'(act_rd_en), 64'd0);
        check("hit_valid_t1", 64'(act_valid), 64'd0);
        cyc(0, 0, 10'h000, 8'h00, 1);
        check("hit_valid_t2", 64'(act_valid),   64'd1);
        check("hit_data",     64'(act_data),    64'hDEADBEEF);
        check("hit_flag",     64'(act_hit),     64'd1);
        check("hit_port",     64'(act_in_port), 64'h3C);
        cyc(0, 0, 10'h000, 8'h00, 1);
        check("hit_valid_t3", 64'(act_valid), 64'd0);

        // ---------------- single miss ----------------
        cyc(1, 0, 10'h077, 8'h11, 1);
        check("miss_rden_t", 64'(act_rd_en), 64'd0);
        cyc(0, 0, 10'h000, 8'h00, 1);
        check("miss_valid_t1", 64'(act_valid), 64'd0);
        cyc(0, 0, 10'h000, 8'h00, 1);
        check("miss_valid_t2", 64'(act_valid),   64'd1);
        check("miss_data",     64'(act_data),    64'h1);
        check("miss_flag",     64'(act_hit),     64'd0);
        check("miss_port",     64'(act_in_port), 64'h11);
        cyc(0, 0, 10'h000, 8'h00, 1);

        // ---------------- alternating burst of 16 ----------------
        outq.delete();
        for (int i = 0; i < 16; i++)
            cyc(1, (i % 2) == 0, 10'(10'h010 + i), 8'(8'h40 + i), 1);
        repeat (6) cyc(0, 0, 10'h000, 8'h00, 1);
        qn = outq.size();
        check("burst_count", 64'(qn), 64'd16);
        for (int i = 0; i < 16; i++)
            if (i < qn)
                check($sformatf("burst_%0d", i), 64'(outq[i]),
                      64'(ent((i % 2) == 0, 10'(10'h010 + i), 8'(8'h40 + i))));
        check("burst_drop", 64'(drop_count), 64'd0);
`ifdef ACTION_LOOKUP_STATS_EN
        exp_hits = 32'd9;
        exp_miss = 32'd9;
`else
        exp_hits = 32'd0;
        exp_miss = 32'd0;
`endif
        check("burst_hits", 64'(hit_count),  64'(exp_hits));
        check("burst_miss", 64'(miss_count), 64'(exp_miss));

        // ---------------- overflow: 12 matches into depth 8 ----------------
        outq.delete();
        for (int i = 0; i < 12; i++) begin
            cyc(1, (i % 3) != 0, 10'(10'h100 + i), 8'(8'h80 + i), 0);
            if (i >= 8) check($sformatf("ovf_rden_%0d", i), 64'(act_rd_en), 64'd0);
        end
        repeat (2) cyc(0, 0, 10'h000, 8'h00, 0);
        check("ovf_drop",   64'(drop_count), 64'd4);
        check("ovf_valid",  64'(act_valid),  64'd1);
        check("ovf_noflow", 64'(outq.size()), 64'd0);
        check("ovf_head",   64'({act_data, act_in_port, act_hit}),
              64'(ent(1'b0, 10'h100, 8'h80)));
        repeat (12) cyc(0, 0, 10'h000, 8'h00, 1);
        qn = outq.size();
        check("ovf_count", 64'(qn), 64'd8);
        for (int i = 0; i < 8; i++)
            if (i < qn)
                check($sformatf("ovf_%0d", i), 64'(outq[i]),
                      64'(ent((i % 3) != 0, 10'(10'h100 + i), 8'(8'h80 + i))));
`ifdef ACTION_LOOKUP_STATS_EN
        exp_hits = 32'd14;
        exp_miss = 32'd12;
`else
        exp_hits = 32'd0;
        exp_miss = 32'd0;
`endif
        check("ovf_hits", 64'(hit_count),  64'(exp_hits));
        check("ovf_miss", 64'(miss_count), 64'(exp_miss));

        // ---------------- fill to 7, then match + simultaneous pop ----------------
        outq.delete();
        for (int i = 0; i < 7; i++)
            cyc(1, 1, 10'(10'h200 + i), 8'(8'hC0 + i), 0);
        repeat (2) cyc(0, 0, 10'h000, 8'h00, 0);
        check("fill_valid", 64'(act_valid), 64'd1);
        cyc(1, 1, 10'h207, 8'hC7, 1);
        check("fill_rden",  64'(act_rd_en),   64'd1);
        check("fill_raddr", 64'(act_rd_addr), 64'h207);
        repeat (12) cyc(0, 0, 10'h000, 8'h00, 1);
        check("fill_drop", 64'(drop_count), 64'd4);
        qn = outq.size();
        check("fill_count", 64'(qn), 64'd8);
        for (int i = 0; i < 8; i++)
            if (i < qn)
                check($sformatf("fill_%0d", i), 64'(outq[i]),
                      64'(ent(1'b1, 10'(10'h200 + i), 8'(8'hC0 + i))));

        // ---------------- reset with 3 in FIFO and S2 valid ----------------
        outq.delete();
        for (int i = 0; i < 4; i++)
            cyc(1, 1, 10'(10'h300 + i), 8'(8'hE0 + i), 0);
        check("pre_rst_valid", 64'(act_valid), 64'd1);
        @(posedge clk);
        #1;
        match_valid = 1'b0;
        reset       = 1'b0;
        #1;
        check("mid_rst_valid", 64'(act_valid),  64'd0);
        check("mid_rst_drop",  64'(drop_count), 64'd0);
        check("mid_rst_hits",  64'(hit_count),  64'd0);
        check("mid_rst_miss",  64'(miss_count), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(1, 1, 10'h02A, 8'h99, 1);
        check("post_rst_rden", 64'(act_rd_en), 64'd1);
        cyc(0, 0, 10'h000, 8'h00, 1);
        check("post_rst_valid_t1", 64'(act_valid), 64'd0);
        cyc(0, 0, 10'h000, 8'h00, 1);
        check("post_rst_valid_t2", 64'(act_valid), 64'd1);
        check("post_rst_entry", 64'({act_data, act_in_port, act_hit}),
              64'(ent(1'b1, 10'h02A, 8'h99)));
        cyc(0, 0, 10'h000, 8'h00, 1);
        check("post_rst_empty", 64'(act_valid), 64'd0);
        check("post_rst_seen",  64'(outq.size()), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
